// File: rtl/uart_print_tx.sv
// uart_print_tx: buffers CPU print words in a small FIFO and serializes them as 8N1 frames on tx.
// Define UART_PRINT_ASCII_HEX_EN to send each word as 8 uppercase hex characters plus '\n'.
module uart_print_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        print_en,
    input  logic [31:0] print_data,
    output logic        tx,
    output logic        full,
    output logic        busy,
    output logic        overflow
);
    // state | meaning
    // IDLE  | line high, pops the FIFO head when one is present
    // START | start bit (low) for one bit period
    // DATA  | eight data bits of the current character, LSB first
    // STOP  | stop bit (high); then next character or back to IDLE

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int ADDR_W       = $clog2(FIFO_DEPTH);
    localparam int PTR_W        = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_PRINT_ASCII_HEX_EN
    localparam logic [3:0] LAST_BYTE = 4'd8;
`else
    localparam logic [3:0] LAST_BYTE = 4'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [3:0]        byte_q, byte_d;
    logic [31:0]       shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic              empty;
    logic              wr_en;
    logic              pop;
    logic              baud_done;
    logic [7:0]        cur_byte_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    // full is the pre-edge value, so a pop on the same edge never rescues a write
    assign wr_en = print_en && !full;
    assign baud_done = (baud_q == CNT_LAST);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        overflow_d = overflow_q | (print_en & full);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= print_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
                    byte_d  = '0;
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 1'b1;
                        state_d = START;
`ifndef UART_PRINT_ASCII_HEX_EN
                        shift_d = {8'h00, shift_q[31:8]};
`endif
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_PRINT_ASCII_HEX_EN
    logic [2:0] nib_sel;
    logic [3:0] nib;
    always_comb begin
        nib_sel = 3'd7 - byte_d[2:0];
        nib     = shift_d[{nib_sel, 2'b00} +: 4];
        if (byte_d == 4'd8) begin
            cur_byte_d = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_byte_d = 8'h30 + {4'h0, nib};
        end else begin
            cur_byte_d = 8'h37 + {4'h0, nib};
        end
    end
`else
    assign cur_byte_d = shift_d[7:0];
`endif

    // tx is registered from the next-state values so the line changes on the same edge as the state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy = !empty || (state_q != IDLE);
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_print_tx.sv
// Directed bench for uart_print_tx at CLKS_PER_BIT=10, FIFO_DEPTH=4; follows UART_PRINT_ASCII_HEX_EN.
module tb_uart_print_tx;
    localparam int CPB = 10;
`ifdef UART_PRINT_ASCII_HEX_EN
    localparam int FPW = 9;
`else
    localparam int FPW = 4;
`endif
    localparam int WORD_CYC = FPW * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        print_en = 1'b0;
    logic [31:0] print_data = '0;
    logic        tx, full, busy, overflow;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    uart_print_tx #(.CLK_FREQ(100), .BAUD_RATE(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .print_en(print_en), .print_data(print_data),
        .tx(tx), .full(full), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
`ifdef UART_PRINT_ASCII_HEX_EN
        logic [3:0] nib;
        if (k == 8) return 8'h0A;
        nib = w[(7 - k) * 4 +: 4];
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
`else
        return w[8 * k +: 8];
`endif
    endfunction

    task automatic do_write(input logic [31:0] d);
        print_en   = 1'b1;
        print_data = d;
        @(negedge clk);
        print_en   = 1'b0;
    endtask

    // st is the edge on which tx went low (first low sample)
    task automatic rx_frame(output logic [7:0] b, output int st, output bit ok);
        int n;
        ok = 1'b0;
        b  = '0;
        st = 0;
        n  = 0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        st = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) return;
        ok = 1'b1;
    endtask

    task automatic receive_word(input logic [31:0] w, input int exp_start);
        logic [7:0] b;
        int st;
        bit ok;
        for (int k = 0; k < FPW; k++) begin
            rx_frame(b, st, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL frame_valid word %h frame %0d: got no valid frame, expected one", w, k);
                return;
            end
            n_cmp++;
            if (b !== exp_byte(w, k)) begin
                n_err++;
                $display("FAIL frame_data word %h frame %0d: got %h, expected %h", w, k, b, exp_byte(w, k));
            end
            n_cmp++;
            if (st != exp_start + k * 10 * CPB) begin
                n_err++;
                $display("FAIL frame_start word %h frame %0d: got cycle %0d, expected %0d",
                         w, k, st, exp_start + k * 10 * CPB);
            end
        end
    endtask

    task automatic wait_idle(input string name, input int exp_cyc);
        int n = 0;
        while (busy === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0 || cyc != exp_cyc) begin
            n_err++;
            $display("FAIL %s: busy=%b falling at cycle %0d, expected 0 at cycle %0d", name, busy, cyc, exp_cyc);
        end
    endtask

    task automatic test_reset();
        bit bad = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
                n_err++;
                bad = 1'b1;
                $display("FAIL reset_state cycle %0d: got tx/busy/full/ovf=%b%b%b%b, expected 1000",
                         i, tx, busy, full, overflow);
            end
            if (bad) break;
        end
    endtask

`ifndef UART_PRINT_ASCII_HEX_EN
    task automatic test_single_word();
        logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        logic [7:0] b;
        int wr, st;
        bit ok;
        do_write(32'h12345678);
        wr = cyc;
        n_cmp++;
        if (busy !== 1'b1 || tx !== 1'b1) begin
            n_err++;
            $display("FAIL single_after_write: got busy=%b tx=%b, expected busy=1 tx=1", busy, tx);
        end
        for (int k = 0; k < 4; k++) begin
            rx_frame(b, st, ok);
            n_cmp++;
            if (!ok || b !== exp[k]) begin
                n_err++;
                $display("FAIL single_frame %0d: got %h (valid=%0d), expected %h", k, b, ok, exp[k]);
            end
            n_cmp++;
            if (st != wr + 1 + k * 100) begin
                n_err++;
                $display("FAIL single_start %0d: got cycle %0d, expected %0d", k, st, wr + 1 + k * 100);
            end
        end
        // busy covers the write cycle through the last stop bit
        wait_idle("single_busy_fall", wr + 401);
    endtask
`endif

    task automatic test_overflow();
        int base;
        bit bad = 1'b0;
        base = cyc + 1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    print_en   = 1'b1;
                    print_data = 32'hA0 + i;
                    @(negedge clk);
                    n_cmp++;
                    if (full !== (i >= 4)) begin
                        n_err++;
                        $display("FAIL ovf_full write %0d: got %b, expected %b", i, full, (i >= 4));
                    end
                    n_cmp++;
                    if (overflow !== (i == 5)) begin
                        n_err++;
                        $display("FAIL ovf_flag write %0d: got %b, expected %b", i, overflow, (i == 5));
                    end
                end
                print_en = 1'b0;
            end
            begin
                for (int w = 0; w < 5; w++) begin
                    receive_word(32'hA0 + w, base + 1 + w * (WORD_CYC + 1));
                end
            end
        join
        wait_idle("ovf_busy_fall", base + 1 + 4 * (WORD_CYC + 1) + WORD_CYC);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || overflow !== 1'b1 || full !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL ovf_no_sixth: got line activity or overflow/full change, expected tx=1 overflow=1 full=0");
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] eb;
        int wr;
        bit bad = 1'b0;
        eb = exp_byte(32'hDEADBEEF, 1);
        do_write(32'hDEADBEEF);
        wr = cyc;
        // middle of data bit 3 of the second frame
        repeat (146) @(negedge clk);
        n_cmp++;
        if (tx !== eb[3]) begin
            n_err++;
            $display("FAIL midrst_bit3: got %b, expected %b", tx, eb[3]);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: got tx/busy/ovf=%b%b%b, expected 100", tx, busy, overflow);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL midrst_quiet: got activity after release (cycle base %0d), expected tx=1 busy=0", wr);
        end
    endtask

    task automatic test_concurrent_pop();
        int c;
        c = cyc;
        fork
            begin
                do_write(32'h0F1E2D3C);
                do_write(32'h11223344);
                n_cmp++;
                if (full !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL cpop_occ: got full=%b busy=%b, expected full=0 busy=1", full, busy);
                end
                repeat (WORD_CYC) @(negedge clk);
                do_write(32'hCAFEF00D);
            end
            begin
                receive_word(32'h0F1E2D3C, c + 2);
                receive_word(32'h11223344, c + 3 + WORD_CYC);
                receive_word(32'hCAFEF00D, c + 4 + 2 * WORD_CYC);
            end
        join
        wait_idle("cpop_busy_fall", c + 4 + 3 * WORD_CYC);
    endtask

`ifdef UART_PRINT_ASCII_HEX_EN
    task automatic test_hex();
        logic [7:0] exp [9] = '{8'h30, 8'h30, 8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45, 8'h0A};
        logic [7:0] b;
        int wr, st;
        bit ok;
        do_write(32'h00C0FFEE);
        wr = cyc;
        for (int k = 0; k < 9; k++) begin
            rx_frame(b, st, ok);
            n_cmp++;
            if (!ok || b !== exp[k]) begin
                n_err++;
                $display("FAIL hex_frame %0d: got %h (valid=%0d), expected %h", k, b, ok, exp[k]);
            end
            n_cmp++;
            if (st != wr + 1 + k * 100) begin
                n_err++;
                $display("FAIL hex_start %0d: got cycle %0d, expected %0d", k, st, wr + 1 + k * 100);
            end
        end
        wait_idle("hex_busy_fall", wr + 901);
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifndef UART_PRINT_ASCII_HEX_EN
        test_single_word();
`endif
        test_overflow();
        test_reset_mid_frame();
        test_concurrent_pop();
`ifdef UART_PRINT_ASCII_HEX_EN
        test_hex();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
